// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory request/response channel,
// redirect from execute, and the instruction handshake toward decode.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  // Fetch stage side.
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    input  redirect_i,
    input  redirect_pc_i,
    output instr_valid_o,
    output instr_o,
    output pc_o,
    input  instr_ready_i
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    output redirect_i,
    output redirect_pc_i,
    input  instr_valid_o,
    input  instr_o,
    input  pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order tag queue
// of granted PCs, instruction buffer toward decode, and redirect handling
// that discards responses still in flight from the abandoned path.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_stage_if.master bus
);

  localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Control state
  logic [31:0] pc;
  cnt_t        outstanding;
  cnt_t        drop_cnt;
  cnt_t        occ;
  ptr_t        tq_rd, tq_wr;
  ptr_t        ff_rd, ff_wr;

  // Data storage (not reset; validity is carried by the pointers/counters)
  logic [31:0] tq_pc    [DEPTH];
  logic [31:0] ff_pc    [DEPTH];
  logic [31:0] ff_instr [DEPTH];

  logic        fifo_empty;
  logic        instr_valid;
  logic        pop;
  logic        req;
  logic        gnt_fire;
  logic        rsp;
  logic        drop_now;
  logic        push;
  logic [CW:0] used;

  // Handshake decode: credits count every in-flight request, dropped or not.
  always_comb begin
    fifo_empty  = (occ == '0);
    instr_valid = !rst_i && !bus.redirect_i && !fifo_empty;
    pop         = instr_valid && bus.instr_ready_i;
    used        = {1'b0, outstanding} + {1'b0, occ} - (CW + 1)'(pop);
    req         = !rst_i && !bus.redirect_i && (used < (CW + 1)'(DEPTH));
    gnt_fire    = req && bus.imem_gnt_i;
    rsp         = !rst_i && bus.imem_rvalid_i;
    drop_now    = rsp && (drop_cnt != '0);
    push        = rsp && !drop_now && !bus.redirect_i;
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = pc;
  assign bus.instr_valid_o = instr_valid;
  assign bus.instr_o       = (rst_i || fifo_empty) ? NOP   : ff_instr[ff_rd];
  assign bus.pc_o          = (rst_i || fifo_empty) ? '0    : ff_pc[ff_rd];

  // Control registers: PC, in-flight count, drop count, queue pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= RESET_PC & ALIGN;
      outstanding <= '0;
      drop_cnt    <= '0;
      occ         <= '0;
      tq_rd       <= '0;
      tq_wr       <= '0;
      ff_rd       <= '0;
      ff_wr       <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(gnt_fire) - cnt_t'(rsp);
      if (bus.redirect_i) begin
        // Everything still in flight belongs to the old path; a response
        // landing this very cycle is already accounted for.
        pc       <= bus.redirect_pc_i & ALIGN;
        drop_cnt <= outstanding - cnt_t'(rsp);
        occ      <= '0;
        tq_rd    <= '0;
        tq_wr    <= '0;
        ff_rd    <= '0;
        ff_wr    <= '0;
      end else begin
        if (gnt_fire) begin
          pc    <= pc + 32'd4;
          tq_wr <= ptr_inc(tq_wr);
        end
        drop_cnt <= drop_cnt - cnt_t'(drop_now);
        if (push) begin
          tq_rd <= ptr_inc(tq_rd);
          ff_wr <= ptr_inc(ff_wr);
        end
        if (pop) begin
          ff_rd <= ptr_inc(ff_rd);
        end
        occ <= occ + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Data path: remember granted PCs, pair each kept response with its PC.
  always_ff @(posedge clk_i) begin
    if (gnt_fire) begin
      tq_pc[tq_wr] <= pc;
    end
    if (push) begin
      ff_pc[ff_wr]    <= tq_pc[tq_rd];
      ff_instr[ff_wr] <= bus.imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: memory responder with configurable latency,
// stream-level reference model of the expected fetch/instruction order,
// directed sequences, a vector table of redirect targets, and random traffic.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          n_grant = 0;
  int          last_due = 0;
  int          lat_cfg = 1;
  bit          rand_lat = 1'b0;
  pend_t       q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_exp_pc;

  logic        d_rst, d_gnt, d_ready, d_redirect;
  logic [31:0] d_rpc;

  logic        s_req, s_valid, s_pop, s_grant;
  logic [31:0] s_addr, s_instr, s_pc;

  vec_t vecs[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_9617;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_true(input string name, input bit cond);
    n_checks++;
    if (!cond) begin
      n_errors++;
      $display("FAIL %s: condition false, expected true (cycle %0d)", name, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample, update reference model.
  task automatic step();
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    rst                = d_rst;
    bus.imem_gnt_i     = d_gnt;
    bus.instr_ready_i  = d_ready;
    bus.redirect_i     = d_redirect;
    bus.redirect_pc_i  = d_rpc;
    if (!d_rst && q.size() > 0 && q[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(q[0].addr);
      void'(q.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
    #1;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_valid = bus.instr_valid_o;
    s_instr = bus.instr_o;
    s_pc    = bus.pc_o;
    s_pop   = s_valid && d_ready;
    s_grant = s_req && d_gnt;
    if (d_rst) begin
      check("rst_req", {31'b0, s_req}, 32'd0);
      check("rst_valid", {31'b0, s_valid}, 32'd0);
      check("rst_instr", s_instr, NOP);
      check("rst_pc", s_pc, 32'd0);
      m_fetch_pc = RESET_PC & 32'hFFFF_FFFC;
      m_exp_pc   = RESET_PC & 32'hFFFF_FFFC;
      q.delete();
      last_due   = 0;
    end else begin
      if (s_grant) begin
        check("fetch_addr", s_addr, m_fetch_pc);
        lat = rand_lat ? int'($urandom_range(1, 3)) : lat_cfg;
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        q.push_back('{addr: s_addr, due: due});
        m_fetch_pc = m_fetch_pc + 32'd4;
        n_grant++;
      end
      if (s_pop) begin
        check("instr_pc", s_pc, m_exp_pc);
        check("instr_word", s_instr, mem_word(m_exp_pc));
        m_exp_pc = m_exp_pc + 32'd4;
        n_pop++;
      end
      if (d_redirect) begin
        check("redirect_valid_low", {31'b0, s_valid}, 32'd0);
        check("redirect_req_low", {31'b0, s_req}, 32'd0);
        m_fetch_pc = d_rpc & 32'hFFFF_FFFC;
        m_exp_pc   = d_rpc & 32'hFFFF_FFFC;
      end
      check_true("outstanding_bound", q.size() <= DEPTH);
    end
  endtask

  task automatic wait_pop(input logic [31:0] exp, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!s_pop && n < 60);
    check_true({name, "_seen"}, s_pop);
    check({name, "_pc"}, s_pc, exp);
  endtask

  task automatic wait_grant(input logic [31:0] exp, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!s_grant && n < 60);
    check_true({name, "_seen"}, s_grant);
    check({name, "_addr"}, s_addr, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid;
    int p0;
    int g0;
    int n;
    logic [31:0] a0;

    vecs[0] = '{target: 32'h0000_0102, exp_a0: 32'h0000_0100, exp_a1: 32'h0000_0104};
    vecs[1] = '{target: 32'h0000_0203, exp_a0: 32'h0000_0200, exp_a1: 32'h0000_0204};
    vecs[2] = '{target: 32'hFFFF_FFFE, exp_a0: 32'hFFFF_FFFC, exp_a1: 32'h0000_0000};
    vecs[3] = '{target: 32'h8000_0007, exp_a0: 32'h8000_0004, exp_a1: 32'h8000_0008};

    rst = 1'b1;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.instr_ready_i = 1'b0;
    m_fetch_pc = RESET_PC;
    m_exp_pc = RESET_PC;

    d_rst = 1'b1; d_gnt = 1'b1; d_ready = 1'b1; d_redirect = 1'b0; d_rpc = '0;
    repeat (3) step();

    // First cycle out of reset: request at RESET_PC, then streaming.
    d_rst = 1'b0;
    step();
    check("first_req", {31'b0, s_req}, 32'd1);
    check("first_addr", s_addr, RESET_PC);
    check("first_valid", {31'b0, s_valid}, 32'd0);
    first_valid = -1;
    p0 = n_pop;
    for (int k = 1; k < 20; k++) begin
      step();
      if (s_valid && first_valid < 0) first_valid = k;
    end
    check("first_valid_latency", first_valid, 32'd2);
    check("stream_pops", n_pop - p0, 32'd18);

    // Decode stall: buffer fills, requests stop, order resumes cleanly.
    d_ready = 1'b0;
    g0 = n_grant;
    repeat (5) step();
    check("stall_valid_held", {31'b0, s_valid}, 32'd1);
    check_true("stall_grants_bounded", (n_grant - g0) <= 2);
    d_ready = 1'b1;
    p0 = n_pop;
    repeat (10) step();
    check_true("stall_resume_pops", (n_pop - p0) >= 8);

    // Grant withheld: address held, PC advances only on grant.
    d_gnt = 1'b0;
    step();
    a0 = s_addr;
    check("gnt_low_req", {31'b0, s_req}, 32'd1);
    repeat (2) begin
      step();
      check("gnt_low_req", {31'b0, s_req}, 32'd1);
      check("gnt_low_addr_hold", s_addr, a0);
    end
    d_gnt = 1'b1;
    step();
    check("gnt_resume_addr", s_addr, a0);
    step();
    check("pc_advance", s_addr, a0 + 32'd4);

    // Redirect with two requests outstanding.
    lat_cfg = 4;
    repeat (8) step();
    n = 0;
    while (q.size() != 2 && n < 10) begin
      step();
      n++;
    end
    check("pre_redirect_outstanding", q.size(), 32'd2);
    d_redirect = 1'b1; d_rpc = 32'h0000_0102;
    step();
    d_redirect = 1'b0;
    wait_grant(32'h0000_0100, "redir_first");
    wait_pop(32'h0000_0100, "redir_first");

    // Back-to-back redirects, latency 2.
    lat_cfg = 2;
    repeat (6) step();
    d_redirect = 1'b1; d_rpc = 32'h0000_0200;
    step();
    d_rpc = 32'h0000_0300;
    step();
    d_redirect = 1'b0;
    wait_pop(32'h0000_0300, "b2b_redirect");
    repeat (6) step();

    // Redirect target table: alignment and address wrap.
    lat_cfg = 1;
    repeat (6) step();
    for (int i = 0; i < 4; i++) begin
      d_redirect = 1'b1; d_rpc = vecs[i].target;
      step();
      d_redirect = 1'b0;
      step();
      check("vec_req", {31'b0, s_req}, 32'd1);
      check("vec_addr0", s_addr, vecs[i].exp_a0);
      step();
      check("vec_addr1", s_addr, vecs[i].exp_a1);
      wait_pop(vecs[i].exp_a0, "vec_first");
    end

    // Random traffic against the reference model.
    rand_lat = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      d_rst      = ($urandom_range(0, 199) == 0);
      d_gnt      = ($urandom_range(0, 9) < 7);
      d_ready    = ($urandom_range(0, 9) < 7);
      d_redirect = !d_rst && ($urandom_range(0, 31) == 0);
      d_rpc      = $urandom;
      step();
    end
    check_true("random_progress", (n_pop - p0) > 100);
    d_rst = 1'b0; d_redirect = 1'b0; d_gnt = 1'b1; d_ready = 1'b1;
    p0 = n_pop;
    repeat (20) step();
    check_true("drain_progress", (n_pop - p0) >= 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have parameter: DEPTH, 2, instruction buffer entries and max in-flight credits (fixed at 2 for this revision).
REQ-003 SHALL have ports:
  clk_i          in   1   single clock, all state on rising edge
  rst_i          in   1   reset, synchronous, active-high
  imem_req_o     out  1   fetch request valid
  imem_addr_o    out  32  fetch address (word_ut), bits [1:0] always 0
  imem_gnt_i     in   1   request accepted this cycle
  imem_rvalid_i  in   1   read data valid, in request order, >=1 cycle after grant
  imem_rdata_i   in   32  fetched instruction word
  redirect_i     in   1   branch/jump taken, flush and restart
  redirect_pc_i  in   32  restart target
  instr_valid_o  out  1   instruction available to decode
  instr_o        out  32  instruction word, drives decode and immediate extension
  pc_o           out  32  address of instr_o
  instr_ready_i  in   1   decode accepts instr_o this cycle
REQ-004 SHALL use one clock and a synchronous, active-high reset; no other clock or reset.

Function
REQ-005 SHALL hold fetch PC register; imem_addr_o = PC.
REQ-006 SHALL assert imem_req_o iff !rst_i, !redirect_i, and (outstanding + occupancy - pop) < DEPTH, pop = instr_valid_o & instr_ready_i.
REQ-007 SHALL advance PC by 4 (mod 2^32, 0xFFFF_FFFC wraps to 0) on imem_req_o & imem_gnt_i.
REQ-008 SHALL hold imem_addr_o stable while imem_req_o high and imem_gnt_i low.
REQ-009 SHALL record the PC of each granted request in a DEPTH-entry in-order tag queue.
REQ-010 SHALL track outstanding = granted minus responded, range 0..DEPTH; grant and response in same cycle leave it unchanged.
REQ-011 SHALL push {tag PC, imem_rdata_i} into the instruction FIFO on each non-dropped imem_rvalid_i; entry visible on outputs next cycle.
REQ-012 SHALL present FIFO head on instr_o/pc_o with instr_valid_o = !empty; pop on instr_valid_o & instr_ready_i.
REQ-013 SHALL, when FIFO empty, drive instr_o = 32'h0000_0013 (NOP), pc_o = 0.
REQ-014 SHALL support simultaneous push and pop (occupancy unchanged); push never occurs when full, guaranteed by REQ-006 credits.
REQ-015 SHALL sustain one instruction per cycle with 1-cycle memory latency and instr_ready_i held high.
REQ-016 SHALL on redirect_i: force instr_valid_o = 0 that cycle, empty FIFO and tag queue next cycle, load PC = {redirect_pc_i[31:2], 2'b00}.
REQ-017 SHALL on redirect_i set drop count = outstanding minus any response arriving that cycle; subsequent responses decrement it and are discarded while nonzero.
REQ-018 SHALL treat a second redirect while drops pending by adding new outstanding to existing drop count; newest target wins.
REQ-019 SHALL issue first request to redirect target in cycle after redirect_i, even while drops pending (credits count dropped requests as outstanding).
REQ-020 SHALL never present an instruction fetched before a redirect after that redirect.

Reset
REQ-021 SHALL while rst_i high: imem_req_o = 0, instr_valid_o = 0, instr_o = 0x00000013, pc_o = 0; next edge PC = RESET_PC, FIFO, tag queue, outstanding, drop count = 0.
REQ-022 SHALL treat reset mid-operation identically; responses arriving after reset for pre-reset requests are the memory's responsibility and not expected.
REQ-023 SHALL issue first request with imem_addr_o = RESET_PC in first cycle rst_i low.

Verification
REQ-024 Reset release, gnt always 1, rvalid 1 cycle later, ready 1 -> addrs 0,4,8,... every cycle; instr_valid_o first high 2 cycles after first grant, then every cycle, pc_o 0,4,8.
REQ-025 instr_ready_i low 5 cycles -> at most 2 requests beyond the buffered ones; FIFO holds 2, no overwrite; on release pc_o continues in order without gap or duplicate.
REQ-026 imem_gnt_i low 3 cycles with req high -> imem_addr_o held constant; PC advances only on grant.
REQ-027 Redirect to 0x0000_0102 with 2 outstanding -> both stale responses dropped; next request addr 0x0000_0100; next instr_valid_o carries pc_o 0x0000_0100.
REQ-028 Back-to-back redirects to 0x200 then 0x300 with latency 2 -> only instructions from 0x300 onward appear; no 0x200 or pre-redirect pc_o.
REQ-029 PC at 0xFFFF_FFFC granted -> next imem_addr_o = 0x0000_0000.
